pipeline_stall_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I core. Merges the load-use stall request,
//  EX-stage branch/jump redirect and instruction/data memory wait handshakes into one set of

---
 rtl/pipe_ctrl_pkg.sv | 5 +
 rtl/pipe_wait_watchdog.sv | 23 ++
 rtl/pipeline_stall_controller.sv | 70 +++++++
 tb/tb_pipeline_stall_controller.sv | 113 +++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and NOP instruction for the pipeline stall controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, ERR = 2'd2} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/pipe_wait_watchdog.sv
// pipe_wait_watchdog: counts consecutive memory-wait cycles and raises a sticky error at the timeout.
module pipe_wait_watchdog #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_cyc,
  output logic timeout,
  output logic err
);
  logic [CNT_W-1:0] cnt;
  // Fires in the wait cycle that brings the count up to WAIT_TIMEOUT.
  assign timeout = wait_cyc && cnt == CNT_W'(WAIT_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= !wait_cyc ? '0 : &cnt ? cnt : cnt + 1'b1;
      err <= err | timeout;
    end
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: merges data/fetch waits, EX redirect and load-use into pipeline enables/flushes.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
import pipe_ctrl_pkg::*;
module pipeline_stall_controller #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 8,
  parameter int PERF_W       = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ldUseHzd,
  input  logic exRedirect,
  input  logic imemReady,
  input  logic dmemReq,
  input  logic dmemReady,
  output logic PcWrite,
  output logic PcSel,
  output logic IfIdWrite,
  output logic IfIdFlush,
  output logic IdExSel,
  output logic ExMemWrite,
  output logic MemWbWrite,
  output logic stallErr
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perfStallCyc,
  output logic [PERF_W-1:0] perfFlushCnt
`endif
);
  state_t state, state_nx;
  logic data_wait, fetch_wait, freeze, timeout;
  assign data_wait  = dmemReq && !dmemReady;
  assign fetch_wait = !imemReady && !exRedirect && !ldUseHzd;
  assign freeze     = state == ERR || data_wait;
  pipe_wait_watchdog #(.WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(CNT_W)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .wait_cyc(state != ERR && (data_wait || fetch_wait)),
    .timeout (timeout),
    .err     (stallErr)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  always_comb
    state_nx = (state == ERR || timeout) ? ERR : data_wait ? DWAIT : RUN;
  // The cycle dmemReady returns behaves as RUN, so a redirect held through the freeze lands then.
  always_comb begin
    PcWrite    = !freeze && (exRedirect || (!ldUseHzd && imemReady));
    PcSel      = !freeze && exRedirect;
    IfIdWrite  = !freeze && (exRedirect || !ldUseHzd);
    IfIdFlush  = !freeze && (exRedirect || (!ldUseHzd && !imemReady));
    IdExSel    = !freeze && (exRedirect || ldUseHzd);
    ExMemWrite = !freeze;
    MemWbWrite = !freeze;
  end
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perfStallCyc <= '0;
      perfFlushCnt <= '0;
    end else if (state != ERR) begin
      perfStallCyc <= perfStallCyc + PERF_W'(!PcWrite);
      perfFlushCnt <= perfFlushCnt + PERF_W'(PcSel);
    end
`else
  logic unused_perf;
  assign unused_perf = |PERF_W;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_pipeline_stall_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ldUseHzd = 1'b0, exRedirect = 1'b0, imemReady = 1'b1, dmemReq = 1'b0, dmemReady = 1'b0;
  logic PcWrite, PcSel, IfIdWrite, IfIdFlush, IdExSel, ExMemWrite, MemWbWrite, stallErr;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perfStallCyc, perfFlushCnt;
`endif
  typedef struct packed {logic [7:0] exp; logic [15:0] id;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, id = 0;
  logic [7:0] got;
  // {PcWrite, PcSel, IfIdWrite, IfIdFlush, IdExSel, ExMemWrite, MemWbWrite, stallErr}
  localparam logic [7:0] IDLE = 8'b1010_0110;
  localparam logic [7:0] LU   = 8'b0000_1110;
  localparam logic [7:0] RD   = 8'b1111_1110;
  localparam logic [7:0] FW   = 8'b0011_0110;
  localparam logic [7:0] FZ   = 8'b0000_0000;
  localparam logic [7:0] ERRV = 8'b0000_0001;
  always #5 clk = ~clk;
  pipeline_stall_controller #(.WAIT_TIMEOUT(4), .CNT_W(8), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ldUseHzd(ldUseHzd), .exRedirect(exRedirect),
    .imemReady(imemReady), .dmemReq(dmemReq), .dmemReady(dmemReady),
    .PcWrite(PcWrite), .PcSel(PcSel), .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush),
    .IdExSel(IdExSel), .ExMemWrite(ExMemWrite), .MemWbWrite(MemWbWrite), .stallErr(stallErr)
`ifdef PIPE_PERF_CNT_EN
    , .perfStallCyc(perfStallCyc), .perfFlushCnt(perfFlushCnt)
`endif
  );
  assign got = {PcWrite, PcSel, IfIdWrite, IfIdFlush, IdExSel, ExMemWrite, MemWbWrite, stallErr};
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL vec%0d outputs got %b want %b", e.id, got, e.exp);
      end
    end
  task automatic step(input logic r, lu, rd, im, dq, dr, input logic [7:0] exp);
    @(posedge clk);
    #1;
    rst_n = r; ldUseHzd = lu; exRedirect = rd; imemReady = im; dmemReq = dq; dmemReady = dr;
    q.push_back({exp, 16'(id)});
    id++;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    step(0, 0, 0, 1, 0, 0, IDLE);
    step(1, 0, 0, 1, 0, 0, IDLE);
    step(1, 1, 0, 1, 0, 0, LU);
    step(1, 0, 0, 1, 0, 0, IDLE);
    step(1, 1, 1, 1, 0, 0, RD);
    step(1, 0, 0, 0, 0, 0, FW);
    step(1, 1, 0, 0, 0, 0, LU);
    step(1, 0, 1, 0, 0, 0, RD);
    repeat (3) step(1, 0, 1, 1, 1, 0, FZ);
    step(1, 0, 1, 1, 1, 1, RD);
    step(1, 0, 0, 1, 1, 1, IDLE);
    repeat (2) step(1, 0, 0, 0, 1, 0, FZ);
    step(1, 0, 0, 0, 0, 0, FW);
    step(1, 0, 0, 1, 0, 0, IDLE);
    repeat (4) step(1, 0, 0, 1, 1, 0, FZ);
    step(1, 0, 1, 1, 1, 1, ERRV);
    step(1, 1, 0, 0, 0, 0, ERRV);
    step(1, 0, 0, 1, 0, 0, ERRV);
    step(0, 0, 0, 1, 0, 0, IDLE);
    step(1, 0, 0, 1, 0, 0, IDLE);
    repeat (3) step(1, 0, 0, 0, 0, 0, FW);
    step(1, 0, 0, 1, 0, 0, IDLE);
    repeat (4) step(1, 0, 0, 0, 0, 0, FW);
    step(1, 0, 0, 1, 0, 0, ERRV);
    step(1, 0, 0, 1, 0, 0, ERRV);
    step(0, 0, 0, 1, 0, 0, IDLE);
    step(1, 0, 0, 1, 1, 0, FZ);
    step(0, 0, 0, 1, 0, 0, IDLE);
    step(1, 0, 0, 1, 0, 0, IDLE);
    step(1, 1, 0, 1, 0, 0, LU);
    step(1, 0, 0, 1, 0, 0, IDLE);
    step(1, 1, 0, 1, 0, 0, LU);
    step(1, 0, 1, 1, 0, 0, RD);
    step(1, 0, 0, 1, 0, 0, IDLE);
`ifdef PIPE_PERF_CNT_EN
    @(negedge clk);
    #1;
    n_chk++;
    if (perfStallCyc !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_stall got %0d want 2", perfStallCyc);
    end
    n_chk++;
    if (perfFlushCnt !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_flush got %0d want 1", perfFlushCnt);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d left want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
